mef_multiciclo: RTL and testbench

Parametrised multicycle control unit for the RV32I core: a Moore/Mealy state machine that decodes `op` into per-state datapath control for fetch, decode, address, memory, execute and write-back. Unlike the fixed five-cycle sequencer, its path length depends on the instruction class. It waits on a memory-ready handshake, traps illegal opcodes and memory time-outs, and counts retired instructions. It sits between the instruction register's opcode field and the datapath muxes, register file and memory of the multicycle core.

---
 rtl/mef_multiciclo.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_mef_multiciclo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mef_multiciclo.sv
// Multicycle control unit for the RV32I core: decodes the opcode into per-state
// datapath controls, waits on memory, traps illegal opcodes / time-outs, counts retires.
module mef_multiciclo #(
    parameter int ANCHO_CONT = 32,
    parameter bit USA_ESPERA = 1'b1,
    parameter int ESPERA_MAX = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic                  mem_listo,
    output logic                  esc_pc,
    output logic                  branch,
    output logic                  esc_inst,
    output logic                  esc_mem,
    output logic                  esc_reg,
    output logic                  lee_mem,
    output logic                  sel_dir,
    output logic [2:0]            sel_inmediato,
    output logic [1:0]            modo_alu,
    output logic [1:0]            sel_op1,
    output logic [1:0]            sel_op2,
    output logic [1:0]            sel_y,
    output logic                  fin_inst,
    output logic [ANCHO_CONT-1:0] instr_retiradas,
    output logic                  trampa,
    output logic [1:0]            causa_trampa
);

    typedef enum logic [3:0] {
        CARGA        = 4'd0,
        DECODIFICA   = 4'd1,
        DIRECCION    = 4'd2,
        LEE_MEM      = 4'd3,
        ESCRIBE_DATO = 4'd4,
        ESCRIBE_MEM  = 4'd5,
        EJECUTA_R    = 4'd6,
        EJECUTA_I    = 4'd7,
        ESCRIBE_ALU  = 4'd8,
        RAMA         = 4'd9,
        SALTO        = 4'd10,
        LUI          = 4'd11,
        TRAMPA       = 4'd12
    } estado_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_RAMA  = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [1:0] CAUSA_ILEGAL = 2'b01;
    localparam logic [1:0] CAUSA_TIEMPO = 2'b10;

    localparam logic [7:0] ESPERA_LIM  = 8'(ESPERA_MAX);
    localparam bit         TIEMPO_ACT  = USA_ESPERA && (ESPERA_MAX != 0);

    estado_t               estado_q, estado_d;
    logic [7:0]            espera_q, espera_d;
    logic [ANCHO_CONT-1:0] cont_q, cont_d;
    logic [1:0]            causa_q, causa_d;

    logic       listo_s;
    logic       espera_s;
    logic       tiempo_s;
    logic       esc_pc_s, branch_s, esc_inst_s, esc_mem_s, esc_reg_s, lee_mem_s, sel_dir_s;
    logic [2:0] sel_inm_s;
    logic [1:0] modo_alu_s, sel_op1_s, sel_op2_s, sel_y_s;
    logic       fin_s;

    // Effective memory handshake and time-out condition for the current cycle
    always_comb begin
        if (USA_ESPERA) begin
            listo_s = mem_listo;
        end else begin
            listo_s = 1'b1;
        end
        espera_s = (estado_q == CARGA) || (estado_q == LEE_MEM) || (estado_q == ESCRIBE_MEM);
        tiempo_s = TIEMPO_ACT && espera_s && !mem_listo && (espera_q == ESPERA_LIM);
    end

    // Next-state and per-state control decode
    always_comb begin
        estado_d   = estado_q;
        causa_d    = causa_q;
        esc_pc_s   = 1'b0;
        branch_s   = 1'b0;
        esc_inst_s = 1'b0;
        esc_mem_s  = 1'b0;
        esc_reg_s  = 1'b0;
        lee_mem_s  = 1'b0;
        sel_dir_s  = 1'b0;
        sel_inm_s  = 3'b000;
        modo_alu_s = 2'b00;
        sel_op1_s  = 2'b00;
        sel_op2_s  = 2'b00;
        sel_y_s    = 2'b00;
        fin_s      = 1'b0;
        case (estado_q)
            CARGA: begin
                lee_mem_s  = 1'b1;
                sel_op2_s  = 2'b10;
                sel_y_s    = 2'b10;
                esc_inst_s = listo_s;
                esc_pc_s   = listo_s;
                if (listo_s) begin
                    estado_d = DECODIFICA;
                end else if (tiempo_s) begin
                    estado_d = TRAMPA;
                    causa_d  = CAUSA_TIEMPO;
                end else begin
                    estado_d = CARGA;
                end
            end
            DECODIFICA: begin
                sel_op1_s = 2'b01;
                sel_op2_s = 2'b01;
                if (op == OP_JAL) begin
                    sel_inm_s = 3'b100;
                end else begin
                    sel_inm_s = 3'b010;
                end
                case (op)
                    OP_LOAD, OP_STORE: estado_d = DIRECCION;
                    OP_R:              estado_d = EJECUTA_R;
                    OP_I:              estado_d = EJECUTA_I;
                    OP_RAMA:           estado_d = RAMA;
                    OP_JAL:            estado_d = SALTO;
                    OP_LUI:            estado_d = LUI;
                    default: begin
                        estado_d = TRAMPA;
                        causa_d  = CAUSA_ILEGAL;
                    end
                endcase
            end
            DIRECCION: begin
                sel_op1_s = 2'b10;
                sel_op2_s = 2'b01;
                if (op == OP_STORE) begin
                    sel_inm_s = 3'b001;
                    estado_d  = ESCRIBE_MEM;
                end else begin
                    sel_inm_s = 3'b000;
                    estado_d  = LEE_MEM;
                end
            end
            LEE_MEM: begin
                sel_dir_s = 1'b1;
                lee_mem_s = 1'b1;
                if (listo_s) begin
                    estado_d = ESCRIBE_DATO;
                end else if (tiempo_s) begin
                    estado_d = TRAMPA;
                    causa_d  = CAUSA_TIEMPO;
                end else begin
                    estado_d = LEE_MEM;
                end
            end
            ESCRIBE_DATO: begin
                sel_y_s   = 2'b01;
                esc_reg_s = 1'b1;
                fin_s     = 1'b1;
                estado_d  = CARGA;
            end
            ESCRIBE_MEM: begin
                sel_dir_s = 1'b1;
                esc_mem_s = 1'b1;
                fin_s     = listo_s;
                if (listo_s) begin
                    estado_d = CARGA;
                end else if (tiempo_s) begin
                    estado_d = TRAMPA;
                    causa_d  = CAUSA_TIEMPO;
                end else begin
                    estado_d = ESCRIBE_MEM;
                end
            end
            EJECUTA_R: begin
                sel_op1_s  = 2'b10;
                sel_op2_s  = 2'b00;
                modo_alu_s = 2'b10;
                estado_d   = ESCRIBE_ALU;
            end
            EJECUTA_I: begin
                sel_op1_s  = 2'b10;
                sel_op2_s  = 2'b01;
                sel_inm_s  = 3'b000;
                modo_alu_s = 2'b10;
                estado_d   = ESCRIBE_ALU;
            end
            ESCRIBE_ALU: begin
                sel_y_s   = 2'b00;
                esc_reg_s = 1'b1;
                fin_s     = 1'b1;
                estado_d  = CARGA;
            end
            RAMA: begin
                sel_op1_s  = 2'b10;
                sel_op2_s  = 2'b00;
                modo_alu_s = 2'b01;
                branch_s   = 1'b1;
                sel_y_s    = 2'b00;
                fin_s      = 1'b1;
                estado_d   = CARGA;
            end
            SALTO: begin
                sel_op1_s = 2'b01;
                sel_op2_s = 2'b10;
                sel_y_s   = 2'b00;
                esc_pc_s  = 1'b1;
                estado_d  = ESCRIBE_ALU;
            end
            LUI: begin
                sel_op1_s = 2'b11;
                sel_op2_s = 2'b01;
                sel_inm_s = 3'b011;
                estado_d  = ESCRIBE_ALU;
            end
            TRAMPA: begin
                estado_d = TRAMPA;
            end
            default: begin
                estado_d = CARGA;
            end
        endcase
    end

    // Wait-cycle counter and retired-instruction count updates
    always_comb begin
        if (estado_d != estado_q) begin
            espera_d = 8'd0;
        end else if (espera_s && !listo_s && (espera_q != 8'hFF)) begin
            espera_d = espera_q + 8'd1;
        end else begin
            espera_d = espera_q;
        end
        if (fin_s) begin
            cont_d = cont_q + {{(ANCHO_CONT-1){1'b0}}, 1'b1};
        end else begin
            cont_d = cont_q;
        end
    end

    // State, wait counter, retire counter and trap cause registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= CARGA;
            espera_q <= 8'd0;
            cont_q   <= '0;
            causa_q  <= 2'b00;
        end else begin
            estado_q <= estado_d;
            espera_q <= espera_d;
            cont_q   <= cont_d;
            causa_q  <= causa_d;
        end
    end

    // Controls are forced low while reset is held, even though the state already reads CARGA
    always_comb begin
        if (reset) begin
            esc_pc        = 1'b0;
            branch        = 1'b0;
            esc_inst      = 1'b0;
            esc_mem       = 1'b0;
            esc_reg       = 1'b0;
            lee_mem       = 1'b0;
            sel_dir       = 1'b0;
            sel_inmediato = 3'b000;
            modo_alu      = 2'b00;
            sel_op1       = 2'b00;
            sel_op2       = 2'b00;
            sel_y         = 2'b00;
            fin_inst      = 1'b0;
            trampa        = 1'b0;
        end else begin
            esc_pc        = esc_pc_s;
            branch        = branch_s;
            esc_inst      = esc_inst_s;
            esc_mem       = esc_mem_s;
            esc_reg       = esc_reg_s;
            lee_mem       = lee_mem_s;
            sel_dir       = sel_dir_s;
            sel_inmediato = sel_inm_s;
            modo_alu      = modo_alu_s;
            sel_op1       = sel_op1_s;
            sel_op2       = sel_op2_s;
            sel_y         = sel_y_s;
            fin_inst      = fin_s;
            trampa        = (estado_q == TRAMPA);
        end
    end

    assign instr_retiradas = cont_q;
    assign causa_trampa    = causa_q;

endmodule

// File: tb/tb_mef_multiciclo.sv
// Directed bench for mef_multiciclo: three instances (default, short time-out,
// no-wait with 2-bit counter) share stimulus; each phase checks the relevant one.
module tb_mef_multiciclo;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       mem_listo;

    int checks;
    int failures;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_RAMA  = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_ILL   = 7'b1110011;

    // {esc_pc,branch,esc_inst,esc_mem,esc_reg,lee_mem,sel_dir, inm, modo, op1, op2, y, fin}
    localparam logic [18:0] E_CERO     = 19'd0;
    localparam logic [18:0] E_CARGA_L  = {7'b1010010, 3'b000, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0};
    localparam logic [18:0] E_CARGA_W  = {7'b0000010, 3'b000, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0};
    localparam logic [18:0] E_DEC_B    = {7'b0000000, 3'b010, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
    localparam logic [18:0] E_DEC_J    = {7'b0000000, 3'b100, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
    localparam logic [18:0] E_DIR_LD   = {7'b0000000, 3'b000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
    localparam logic [18:0] E_DIR_ST   = {7'b0000000, 3'b001, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
    localparam logic [18:0] E_LEE      = {7'b0000011, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] E_ESC_DATO = {7'b0000100, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1};
    localparam logic [18:0] E_ESC_MEM  = {7'b0001001, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [18:0] E_EJ_R     = {7'b0000000, 3'b000, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [18:0] E_ESC_ALU  = {7'b0000100, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [18:0] E_RAMA     = {7'b0100000, 3'b000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b1};
    localparam logic [18:0] E_SALTO    = {7'b1000000, 3'b000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};

    logic a_esc_pc, a_branch, a_esc_inst, a_esc_mem, a_esc_reg, a_lee_mem, a_sel_dir, a_fin, a_trampa;
    logic [2:0]  a_inm;
    logic [1:0]  a_modo, a_op1, a_op2, a_y, a_causa;
    logic [31:0] a_cnt;
    logic b_esc_pc, b_branch, b_esc_inst, b_esc_mem, b_esc_reg, b_lee_mem, b_sel_dir, b_fin, b_trampa;
    logic [2:0]  b_inm;
    logic [1:0]  b_modo, b_op1, b_op2, b_y, b_causa;
    logic [31:0] b_cnt;
    logic c_esc_pc, c_branch, c_esc_inst, c_esc_mem, c_esc_reg, c_lee_mem, c_sel_dir, c_fin, c_trampa;
    logic [2:0]  c_inm;
    logic [1:0]  c_modo, c_op1, c_op2, c_y, c_causa;
    logic [1:0]  c_cnt;

    logic [18:0] a_ctl, b_ctl, c_ctl;
    assign a_ctl = {a_esc_pc, a_branch, a_esc_inst, a_esc_mem, a_esc_reg, a_lee_mem, a_sel_dir,
                    a_inm, a_modo, a_op1, a_op2, a_y, a_fin};
    assign b_ctl = {b_esc_pc, b_branch, b_esc_inst, b_esc_mem, b_esc_reg, b_lee_mem, b_sel_dir,
                    b_inm, b_modo, b_op1, b_op2, b_y, b_fin};
    assign c_ctl = {c_esc_pc, c_branch, c_esc_inst, c_esc_mem, c_esc_reg, c_lee_mem, c_sel_dir,
                    c_inm, c_modo, c_op1, c_op2, c_y, c_fin};

    mef_multiciclo u_a (
        .clk(clk), .reset(reset), .op(op), .mem_listo(mem_listo),
        .esc_pc(a_esc_pc), .branch(a_branch), .esc_inst(a_esc_inst), .esc_mem(a_esc_mem),
        .esc_reg(a_esc_reg), .lee_mem(a_lee_mem), .sel_dir(a_sel_dir), .sel_inmediato(a_inm),
        .modo_alu(a_modo), .sel_op1(a_op1), .sel_op2(a_op2), .sel_y(a_y), .fin_inst(a_fin),
        .instr_retiradas(a_cnt), .trampa(a_trampa), .causa_trampa(a_causa)
    );

    mef_multiciclo #(.ESPERA_MAX(4)) u_b (
        .clk(clk), .reset(reset), .op(op), .mem_listo(mem_listo),
        .esc_pc(b_esc_pc), .branch(b_branch), .esc_inst(b_esc_inst), .esc_mem(b_esc_mem),
        .esc_reg(b_esc_reg), .lee_mem(b_lee_mem), .sel_dir(b_sel_dir), .sel_inmediato(b_inm),
        .modo_alu(b_modo), .sel_op1(b_op1), .sel_op2(b_op2), .sel_y(b_y), .fin_inst(b_fin),
        .instr_retiradas(b_cnt), .trampa(b_trampa), .causa_trampa(b_causa)
    );

    mef_multiciclo #(.ANCHO_CONT(2), .USA_ESPERA(1'b0)) u_c (
        .clk(clk), .reset(reset), .op(op), .mem_listo(mem_listo),
        .esc_pc(c_esc_pc), .branch(c_branch), .esc_inst(c_esc_inst), .esc_mem(c_esc_mem),
        .esc_reg(c_esc_reg), .lee_mem(c_lee_mem), .sel_dir(c_sel_dir), .sel_inmediato(c_inm),
        .modo_alu(c_modo), .sel_op1(c_op1), .sel_op2(c_op2), .sel_y(c_y), .fin_inst(c_fin),
        .instr_retiradas(c_cnt), .trampa(c_trampa), .causa_trampa(c_causa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle, apply mem_listo, let combinational outputs settle
    task automatic step(input logic ml);
        @(posedge clk);
        #2;
        mem_listo = ml;
        #2;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        op        = OP_R;
        mem_listo = 1'b1;

        // Reset state on all instances
        step(1'b1);
        step(1'b1);
        chk("rst_ctl_a", 32'(a_ctl), 32'(E_CERO));
        chk("rst_ctl_b", 32'(b_ctl), 32'(E_CERO));
        chk("rst_ctl_c", 32'(c_ctl), 32'(E_CERO));
        chk("rst_cnt_a", a_cnt, 32'd0);
        chk("rst_trampa_a", 32'(a_trampa), 32'd0);
        chk("rst_causa_a", 32'(a_causa), 32'd0);

        // R-type, no wait
        reset = 1'b0;
        #1;
        chk("r_c1_carga", 32'(a_ctl), 32'(E_CARGA_L));
        step(1'b1); chk("r_c2_dec", 32'(a_ctl), 32'(E_DEC_B));
        step(1'b1); chk("r_c3_ejr", 32'(a_ctl), 32'(E_EJ_R));
        step(1'b1); chk("r_c4_escalu", 32'(a_ctl), 32'(E_ESC_ALU));
        chk("r_c4_cnt", a_cnt, 32'd0);
        step(1'b1); chk("r_c5_carga", 32'(a_ctl), 32'(E_CARGA_L));
        chk("r_cnt1", a_cnt, 32'd1);

        // Load with three wait cycles in LEE_MEM: eight cycles total
        op = OP_LOAD;
        step(1'b1); chk("ld_c2_dec", 32'(a_ctl), 32'(E_DEC_B));
        step(1'b1); chk("ld_c3_dir", 32'(a_ctl), 32'(E_DIR_LD));
        step(1'b0); chk("ld_c4_lee", 32'(a_ctl), 32'(E_LEE));
        step(1'b0); chk("ld_c5_lee", 32'(a_ctl), 32'(E_LEE));
        step(1'b0); chk("ld_c6_lee", 32'(a_ctl), 32'(E_LEE));
        step(1'b1); chk("ld_c7_lee", 32'(a_ctl), 32'(E_LEE));
        step(1'b1); chk("ld_c8_escdato", 32'(a_ctl), 32'(E_ESC_DATO));
        step(1'b1); chk("ld_next_carga", 32'(a_ctl), 32'(E_CARGA_L));
        chk("ld_cnt2", a_cnt, 32'd2);

        // Reset asserted mid-stream clears the count and outputs immediately
        reset = 1'b1;
        #1;
        chk("rst2_ctl", 32'(a_ctl), 32'(E_CERO));
        chk("rst2_cnt", a_cnt, 32'd0);

        // Branch then JAL
        op = OP_RAMA;
        step(1'b1);
        reset = 1'b0;
        #1;
        chk("br_c1_carga", 32'(a_ctl), 32'(E_CARGA_L));
        step(1'b1); chk("br_c2_dec", 32'(a_ctl), 32'(E_DEC_B));
        step(1'b1); chk("br_c3_rama", 32'(a_ctl), 32'(E_RAMA));
        op = OP_JAL;
        step(1'b1); chk("jal_carga", 32'(a_ctl), 32'(E_CARGA_L));
        chk("jal_cnt1", a_cnt, 32'd1);
        step(1'b1); chk("jal_dec_j", 32'(a_ctl), 32'(E_DEC_J));
        step(1'b1); chk("jal_salto", 32'(a_ctl), 32'(E_SALTO));
        step(1'b1);
        step(1'b1);
        chk("jal_cnt2_after8", a_cnt, 32'd2);

        // Illegal opcode traps after DECODIFICA and stays until reset
        reset = 1'b1;
        op    = OP_ILL;
        step(1'b1);
        reset = 1'b0;
        #1;
        chk("ill_c1_carga", 32'(a_ctl), 32'(E_CARGA_L));
        step(1'b1); chk("ill_c2_dec", 32'(a_ctl), 32'(E_DEC_B));
        step(1'b1);
        chk("ill_trampa", 32'(a_trampa), 32'd1);
        chk("ill_causa", 32'(a_causa), 32'd1);
        chk("ill_ctl", 32'(a_ctl), 32'(E_CERO));
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(1, 0)));
            chk("ill_hold", {13'd0, a_ctl}, {13'd0, E_CERO} | {31'd0, !a_trampa});
        end
        chk("ill_hold_causa", 32'(a_causa), 32'd1);
        reset = 1'b1;
        #1;
        chk("ill_rst_trampa", 32'(a_trampa), 32'd0);
        chk("ill_rst_causa", 32'(a_causa), 32'd0);

        // Time-out with ESPERA_MAX=4 while waiting in CARGA
        op = OP_R;
        step(1'b0);
        reset = 1'b0;
        #1;
        chk("to_c1_carga", 32'(b_ctl), 32'(E_CARGA_W));
        for (int i = 2; i <= 5; i++) begin
            step(1'b0);
            chk("to_wait_carga", 32'(b_ctl), 32'(E_CARGA_W));
            chk("to_wait_notrap", 32'(b_trampa), 32'd0);
        end
        step(1'b0);
        chk("to_trampa", 32'(b_trampa), 32'd1);
        chk("to_causa", 32'(b_causa), 32'd2);
        chk("to_ctl", 32'(b_ctl), 32'(E_CERO));
        chk("to_default_notrap", 32'(a_trampa), 32'd0);

        // Same wait but mem_listo arrives on the fifth cycle: no trap
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        #1;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1); chk("to2_c5_carga", 32'(b_ctl), 32'(E_CARGA_L));
        step(1'b1); chk("to2_c6_dec", 32'(b_ctl), 32'(E_DEC_B));
        chk("to2_notrap", 32'(b_trampa), 32'd0);

        // No-wait instance: five stores wrap the 2-bit counter 3->0->1
        reset = 1'b1;
        op    = OP_STORE;
        step(1'b0);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("st_cnt", 32'(c_cnt), 32'(k % 4));
            chk("st_carga", 32'(c_ctl), 32'(E_CARGA_L));
            step(1'b0); chk("st_dec", 32'(c_ctl), 32'(E_DEC_B));
            step(1'b0); chk("st_dir", 32'(c_ctl), 32'(E_DIR_ST));
            step(1'b0); chk("st_escmem", 32'(c_ctl), 32'(E_ESC_MEM));
            step(1'b0);
        end
        chk("st_wrap_cnt1", 32'(c_cnt), 32'd1);
        step(1'b0);
        step(1'b0); chk("st6_dir", 32'(c_ctl), 32'(E_DIR_ST));
        reset = 1'b1;
        #1;
        chk("st6_rst_ctl", 32'(c_ctl), 32'(E_CERO));
        chk("st6_rst_cnt", 32'(c_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
